board_move_controller: RTL
==========================

# board_move_controller

Sequences all updates to the shared chess board state consumed by the LCD renderer. Converts cursor and enter/esc inputs into select/move/capture operations on the per-piece location and alive vectors, and alternates the side to move. Sits between the keypad/cursor logic and the LCD block; it is the only writer of board state.

## Interface
- `SLOTS`, 16: piece slots per colour. Slot 0 king, 1 queen, 2–3 bishops, 4–5 knights, 6–7 rooks, 8–15 pawns.
- `SLOT_W`, 6: bits per slot, `{row[2:0], col[2:0]}`.

Ports:
- `clk12` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cursor` in 6: `{row, col}` of the highlighted square, synchronous to `clk12`.
- `enter_pressed` in 1: debounced level, synchronous to `clk12`.
- `esc_pressed` in 1: debounced level, synchronous to `clk12`.
- `vsync` in 1: LCD VSYNC pulse, high during the vertical sync interval.
- `location_vectors_w` out 96: white slot k at `[6k+5:6k]`.
- `location_vectors_b` out 96: black slot k at `[6k+5:6k]`.
- `alive_vectors_w` out 16: white alive bits, one per slot.
- `alive_vectors_b` out 16: black alive bits, one per slot.
- `player` out 1: side to move; 0 white, 1 black.
- `sel_valid` out 1: a source piece is selected.
- `sel_square` out 6: square of the selected piece.
- `busy` out 1: high in SCAN, WAIT_BLANK or COMMIT.
- `move_done` out 1: one-cycle pulse when a move commits.

## Operation
- Enter and esc are edge-detected by registering the previous level. Only a 0→1 transition acts.
- On an enter edge, `cursor` is latched as `tgt` and the block enters SCAN.

States:
- **IDLE**: no selection.
  - Enter edge → SCAN (source search).
  - Esc edge: no effect.
- **SCAN**: 16 cycles, one slot per cycle, index k = 15 down to 0. Both colours are compared each cycle against `tgt`, alive slots only. Records `own_hit` and `own_k` (side to move), and `opp_hit` and `opp_k` (other side).
  - Source search with `own_hit` → SELECTED: `sel_square` = `tgt`, `src_k` = `own_k`.
  - Source search without `own_hit` → IDLE.
  - Destination search with `own_hit` and `tgt` == `sel_square` → IDLE (deselect).
  - Destination search with `own_hit` on another square → SELECTED (reselect: new `src_k`, new `sel_square`).
  - Destination search without `own_hit` → WAIT_BLANK.
- **SELECTED**:
  - Enter edge → SCAN (destination search).
  - Esc edge → IDLE.
- **WAIT_BLANK**: hold until `vsync` = 1, then → COMMIT.
- **COMMIT**: single cycle, then → IDLE.
  - Own slot `src_k` ← `tgt`.
  - If `opp_hit`: opponent `alive[opp_k]` ← 0; its location is unchanged.
  - `player` toggles and `move_done` pulses.
- No legality checking beyond the rules above.
- Boundary rules:
  - Enter and esc edges arriving in SCAN, WAIT_BLANK or COMMIT are ignored.
  - Simultaneous enter and esc edges in SELECTED: esc wins.
  - `sel_valid` = 1 only in SELECTED and during the destination search that follows it.

## Timing
Reset values:
- `location_vectors_w` = 96'h20928B30D38F0070460850C4
- `location_vectors_b` = 96'hC31CB3D35DB7E3FE7EEBDEFC
- `alive_vectors_w` = `alive_vectors_b` = 16'hFFFF
- `player`, `sel_valid`, `busy`, `move_done` = 0
- `sel_square` = 0
- State = IDLE

Latencies:
- Enter edge to SCAN entry: 1 cycle.
- SCAN: 16 cycles.
- Decision: registered on the cycle after the last slot is compared.
- COMMIT begins the cycle after `vsync` is sampled high.
- Board outputs change only on the COMMIT clock edge.

Reset asserted mid-operation: every register returns to its reset value on the next edge, and any partial move is discarded.

## Configuration
`BOARD_VBLANK_COMMIT_EN`:
- Defined: WAIT_BLANK gates COMMIT on `vsync`, so the renderer never sees a half-updated frame.
- Undefined: WAIT_BLANK is bypassed and SCAN goes directly to COMMIT. Commit latency is then 18 cycles after the enter edge, and `vsync` is unused.

## Structure
- Shared package `chess_pkg`:
  - Slot index constants (`KING_SLOT` … `PAWN_BASE`).
  - Reset vector constants for both colours.
  - `square_t` (6 bits).
  - State enum.
- One sub-module, `square_slot_scanner`: slot counter, per-colour compare, and hit/index capture, with start/done handshake.

## Test plan
1. Reset.
   - Outputs equal the reset values above; `player` = 0.
2. Cursor 6'o17, enter; cursor 6'o37, enter; `vsync` pulse.
   - Bits `[53:48]` of `location_vectors_w` = 6'o37.
   - `player` = 1.
   - `move_done` pulses once.
3. Cursor 6'o17, enter; cursor 6'o74, enter; `vsync`.
   - `alive_vectors_b[0]` = 0.
   - White slot 8 = 6'o74.
4. Cursor 6'o17, enter; esc.
   - `sel_valid` = 0; board unchanged.
   - Enter and esc on the same cycle after a selection: esc wins.
5. Cursor 6'o34 (empty square), enter.
   - After 17 cycles: IDLE, `sel_valid` = 0.
   - Enter on 6'o17, then enter on 6'o17 again: deselect.
6. Move pending in WAIT_BLANK, `vsync` held low for 1000 cycles, then reset.
   - No commit occurs.
   - All outputs return to their reset values.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared board definitions: slot layout, reset placement and the move-controller state enum.
// Latency: none, declarations only.
// Backpressure: not applicable.
package chess_pkg;

  localparam int SLOTS  = 16;
  localparam int SLOT_W = 6;

  // Slot roles, identical for both colours.
  localparam int KING_SLOT   = 0;
  localparam int QUEEN_SLOT  = 1;
  localparam int BISHOP_BASE = 2;
  localparam int KNIGHT_BASE = 4;
  localparam int ROOK_BASE   = 6;
  localparam int PAWN_BASE   = 8;

  // Opening position; slot k lives at [6k+5:6k] as {row, col}.
  localparam logic [SLOTS*SLOT_W-1:0] WHITE_RESET_LOC = 96'h20928B30D38F0070460850C4;
  localparam logic [SLOTS*SLOT_W-1:0] BLACK_RESET_LOC = 96'hC31CB3D35DB7E3FE7EEBDEFC;

  typedef logic [SLOT_W-1:0] square_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SELECTED,
    ST_WAIT_BLANK,
    ST_COMMIT
  } board_state_t;

  function automatic square_t slot_square(input logic [SLOTS*SLOT_W-1:0] vec,
                                          input logic [3:0] k);
    return vec[int'(k)*SLOT_W +: SLOT_W];
  endfunction

endpackage

// File: rtl/square_slot_scanner.sv
// Walks slots 15..0, comparing both colours' alive pieces against a target square.
// Latency: start pulse, 16 compare cycles, then done is high for one cycle.
// Backpressure: none; results hold until the next start.
// Ports: clk12/reset; start, player, tgt, loc_w/loc_b, alive_w/alive_b in;
//        done, own_hit/own_k (side to move), opp_hit/opp_k (other side) out.
module square_slot_scanner
  import chess_pkg::*;
(
  input  logic        clk12,
  input  logic        reset,
  input  logic        start,
  input  logic        player,
  input  logic [5:0]  tgt,
  input  logic [95:0] loc_w,
  input  logic [95:0] loc_b,
  input  logic [15:0] alive_w,
  input  logic [15:0] alive_b,
  output logic        done,
  output logic        own_hit,
  output logic [3:0]  own_k,
  output logic        opp_hit,
  output logic [3:0]  opp_k
);

  logic        running;
  logic [3:0]  k;
  logic [95:0] own_loc;
  logic [95:0] opp_loc;
  logic [15:0] own_alive;
  logic [15:0] opp_alive;
  logic        own_match;
  logic        opp_match;

  assign own_loc   = player ? loc_b   : loc_w;
  assign opp_loc   = player ? loc_w   : loc_b;
  assign own_alive = player ? alive_b : alive_w;
  assign opp_alive = player ? alive_w : alive_b;

  // Captured pieces keep their last square, so the alive bit gates the match.
  assign own_match = own_alive[k] && (slot_square(own_loc, k) == tgt);
  assign opp_match = opp_alive[k] && (slot_square(opp_loc, k) == tgt);

  always_ff @(posedge clk12) begin
    if (reset) begin
      running <= 1'b0;
      k       <= 4'd0;
      done    <= 1'b0;
      own_hit <= 1'b0;
      own_k   <= 4'd0;
      opp_hit <= 1'b0;
      opp_k   <= 4'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running <= 1'b1;
        k       <= 4'd15;
        own_hit <= 1'b0;
        own_k   <= 4'd0;
        opp_hit <= 1'b0;
        opp_k   <= 4'd0;
      end else if (running) begin
        if (own_match) begin
          own_hit <= 1'b1;
          own_k   <= k;
        end
        if (opp_match) begin
          opp_hit <= 1'b1;
          opp_k   <= k;
        end
        if (k == 4'd0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
        k <= k - 4'd1;
      end
    end
  end

endmodule

// File: rtl/board_move_controller.sv
// Sole writer of board state: turns cursor + enter/esc edges into select/move/capture updates.
// Latency: enter edge -> SCAN next cycle; decision 17 cycles after the edge; commit after vsync
//          (BOARD_VBLANK_COMMIT_EN) or 18 cycles after the edge when that macro is undefined.
// Backpressure: key edges arriving while busy are dropped, not queued.
// Ports: clk12/reset; cursor, enter_pressed, esc_pressed, vsync in;
//        location/alive vectors per colour, player, sel_valid, sel_square, busy, move_done out.
module board_move_controller
  import chess_pkg::*;
(
  input  logic        clk12,
  input  logic        reset,
  input  logic [5:0]  cursor,
  input  logic        enter_pressed,
  input  logic        esc_pressed,
  input  logic        vsync,
  output logic [95:0] location_vectors_w,
  output logic [95:0] location_vectors_b,
  output logic [15:0] alive_vectors_w,
  output logic [15:0] alive_vectors_b,
  output logic        player,
  output logic        sel_valid,
  output logic [5:0]  sel_square,
  output logic        busy,
  output logic        move_done
);

  board_state_t state;
  board_state_t state_nxt;

  logic       enter_q;
  logic       esc_q;
  logic       enter_edge;
  logic       esc_edge;
  square_t    tgt;
  logic       dest_search;
  logic [3:0] src_k;
  logic       scan_start;
  logic       sel_load;

  logic       scan_done;
  logic       own_hit;
  logic [3:0] own_k;
  logic       opp_hit;
  logic [3:0] opp_k;

  assign enter_edge = enter_pressed & ~enter_q;
  assign esc_edge   = esc_pressed & ~esc_q;

`ifndef BOARD_VBLANK_COMMIT_EN
  logic unused_vsync;
  assign unused_vsync = vsync;
`endif

  square_slot_scanner u_scanner (
    .clk12   (clk12),
    .reset   (reset),
    .start   (scan_start),
    .player  (player),
    .tgt     (tgt),
    .loc_w   (location_vectors_w),
    .loc_b   (location_vectors_b),
    .alive_w (alive_vectors_w),
    .alive_b (alive_vectors_b),
    .done    (scan_done),
    .own_hit (own_hit),
    .own_k   (own_k),
    .opp_hit (opp_hit),
    .opp_k   (opp_k)
  );

  always_ff @(posedge clk12) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    scan_start = 1'b0;
    sel_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enter_edge) begin
          state_nxt  = ST_SCAN;
          scan_start = 1'b1;
        end
      end
      ST_SELECTED: begin
        // Esc has priority over a simultaneous enter.
        if (esc_edge) begin
          state_nxt = ST_IDLE;
        end else if (enter_edge) begin
          state_nxt  = ST_SCAN;
          scan_start = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_done) begin
          if (!dest_search) begin
            if (own_hit) begin
              state_nxt = ST_SELECTED;
              sel_load  = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else if (own_hit) begin
            // Own piece at the target: same square deselects, another square reselects.
            if (tgt == sel_square) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_SELECTED;
              sel_load  = 1'b1;
            end
          end else begin
`ifdef BOARD_VBLANK_COMMIT_EN
            state_nxt = ST_WAIT_BLANK;
`else
            state_nxt = ST_COMMIT;
`endif
          end
        end
      end
`ifdef BOARD_VBLANK_COMMIT_EN
      ST_WAIT_BLANK: begin
        if (vsync) state_nxt = ST_COMMIT;
      end
`endif
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign sel_valid = (state == ST_SELECTED) || ((state == ST_SCAN) && dest_search);
  assign busy      = (state == ST_SCAN) || (state == ST_WAIT_BLANK) || (state == ST_COMMIT);

  always_ff @(posedge clk12) begin
    if (reset) begin
      enter_q            <= 1'b0;
      esc_q              <= 1'b0;
      tgt                <= '0;
      dest_search        <= 1'b0;
      src_k              <= 4'd0;
      sel_square         <= 6'd0;
      location_vectors_w <= WHITE_RESET_LOC;
      location_vectors_b <= BLACK_RESET_LOC;
      alive_vectors_w    <= 16'hFFFF;
      alive_vectors_b    <= 16'hFFFF;
      player             <= 1'b0;
      move_done          <= 1'b0;
    end else begin
      enter_q   <= enter_pressed;
      esc_q     <= esc_pressed;
      move_done <= 1'b0;
      if (scan_start) begin
        tgt         <= cursor;
        dest_search <= (state == ST_SELECTED);
      end
      if (sel_load) begin
        sel_square <= tgt;
        src_k      <= own_k;
      end
      // Scanner hit registers are still valid here; they only clear on the next start.
      if (state == ST_COMMIT) begin
        if (player) begin
          location_vectors_b[int'(src_k)*SLOT_W +: SLOT_W] <= tgt;
          if (opp_hit) alive_vectors_w[opp_k] <= 1'b0;
        end else begin
          location_vectors_w[int'(src_k)*SLOT_W +: SLOT_W] <= tgt;
          if (opp_hit) alive_vectors_b[opp_k] <= 1'b0;
        end
        player    <= ~player;
        move_done <= 1'b1;
      end
    end
  end

endmodule
